// File: rtl/wb_write_merger.sv
// wb_write_merger
// Write-side front end of the register file. The in-order WB stage and the
// long-latency MDU share one register write port. MDU results wait in a
// small circular FIFO and are written in cycles where the pipeline leaves
// the port idle. The block also reports which ID-stage sources still have a
// queued MDU write, and asks for a pipeline bubble if the queue is starved.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   PipeWriteData/Addr/RegWrite_wb  WB-stage write request (always wins)
//   MduData/MduAddr/MduValid      MDU result offer; MduReady accepts it
//   RsAddr_id/RtAddr_id           ID-stage sources; RsPend/RtPend are hits
//   RegWriteData/Addr/RegWrite_wb merged register-file write port
//   StallReq                      one bubble wanted to drain the FIFO head
//   Count                         FIFO occupancy, 0..DEPTH
module wb_write_merger #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                PipeWriteData_wb,
   input  logic [4:0]                 PipeWriteAddr_wb,
   input  logic                       PipeRegWrite_wb,
   input  logic [31:0]                MduData,
   input  logic [4:0]                 MduAddr,
   input  logic                       MduValid,
   output logic                       MduReady,
   input  logic [4:0]                 RsAddr_id,
   input  logic [4:0]                 RtAddr_id,
   output logic                       RsPend,
   output logic                       RtPend,
   output logic [31:0]                RegWriteData_wb,
   output logic [4:0]                 RegWriteAddr_wb,
   output logic                       RegWrite_wb,
   output logic                       StallReq,
   output logic [$clog2(DEPTH):0]     Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_PRE = SW'(STARVE_LIMIT - 1);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic [DEPTH-1:0] r_live;
   logic [4:0]       r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic [SW-1:0]    r_starve;
   logic             r_stall;

   logic w_pipe_busy;
   logic w_nonempty;
   logic w_head_live;
   logic w_pop;
   logic w_push;
   logic w_live_pop;
   logic w_blocked;

   assign w_pipe_busy = PipeRegWrite_wb && (PipeWriteAddr_wb != 5'd0);
   assign w_nonempty  = (r_count != '0);
   // Gated by rst so a reset cycle never leaks a queued write onto the port.
   assign w_head_live = !rst && w_nonempty && r_live[r_rd_ptr];
   // Dead heads (killed or already drained) retire without using the port.
   assign w_pop       = w_nonempty && (!r_live[r_rd_ptr] || !w_pipe_busy);
   assign w_live_pop  = w_head_live && !w_pipe_busy;
   assign w_blocked   = w_head_live && w_pipe_busy;

   // No credit for a same-cycle pop: keeps MduReady off the port mux path.
   assign MduReady = !rst && (r_count < FULL_C);
   assign w_push   = MduValid && MduReady && (MduAddr != 5'd0);

   always_comb begin
      RegWriteData_wb = PipeWriteData_wb;
      RegWriteAddr_wb = PipeWriteAddr_wb;
      RegWrite_wb     = w_pipe_busy;
      if (!w_pipe_busy && w_head_live) begin
         RegWriteData_wb = r_data[r_rd_ptr];
         RegWriteAddr_wb = r_addr[r_rd_ptr];
         RegWrite_wb     = 1'b1;
      end
   end

   always_comb begin
      RsPend = 1'b0;
      RtPend = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_live[i] && (r_addr[i] == RsAddr_id)) RsPend = 1'b1;
         if (r_live[i] && (r_addr[i] == RtAddr_id)) RtPend = 1'b1;
      end
      if (RsAddr_id == 5'd0) RsPend = 1'b0;
      if (RtAddr_id == 5'd0) RtPend = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= MduAddr;
         r_data[r_wr_ptr] <= MduData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_live   <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else begin
         // The pipeline write is younger than anything queued to the same reg.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_busy && (r_addr[i] == PipeWriteAddr_wb)) r_live[i] <= 1'b0;
         end
         if (w_pop) begin
            r_live[r_rd_ptr] <= 1'b0;
            r_rd_ptr         <= r_rd_ptr + PTR_ONE;
         end
         // Assigned last: a same-cycle push to the killed register is newer.
         if (w_push) begin
            r_live[r_wr_ptr] <= 1'b1;
            r_wr_ptr         <= r_wr_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase

         // Emptying also drops the request so a fully killed queue cannot
         // leave StallReq stuck high.
         if (!w_nonempty || w_live_pop) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
         end else if (w_blocked) begin
            if (r_starve != STARVE_MAX) r_starve <= r_starve + STARVE_ONE;
            if (r_starve == STARVE_PRE) r_stall <= 1'b1;
         end
      end
   end

   assign StallReq = r_stall;
   assign Count    = r_count;

endmodule

// File: tb/tb_wb_write_merger.sv
module tb_wb_write_merger;

   logic        clk;
   logic        rst;
   logic [31:0] PipeWriteData_wb;
   logic [4:0]  PipeWriteAddr_wb;
   logic        PipeRegWrite_wb;
   logic [31:0] MduData;
   logic [4:0]  MduAddr;
   logic        MduValid;
   logic        MduReady;
   logic [4:0]  RsAddr_id;
   logic [4:0]  RtAddr_id;
   logic        RsPend;
   logic        RtPend;
   logic [31:0] RegWriteData_wb;
   logic [4:0]  RegWriteAddr_wb;
   logic        RegWrite_wb;
   logic        StallReq;
   logic [2:0]  Count;

   int n_vec  = 0;
   int n_miss = 0;

   wb_write_merger #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .PipeWriteData_wb (PipeWriteData_wb),
      .PipeWriteAddr_wb (PipeWriteAddr_wb),
      .PipeRegWrite_wb  (PipeRegWrite_wb),
      .MduData          (MduData),
      .MduAddr          (MduAddr),
      .MduValid         (MduValid),
      .MduReady         (MduReady),
      .RsAddr_id        (RsAddr_id),
      .RtAddr_id        (RtAddr_id),
      .RsPend           (RsPend),
      .RtPend           (RtPend),
      .RegWriteData_wb  (RegWriteData_wb),
      .RegWriteAddr_wb  (RegWriteAddr_wb),
      .RegWrite_wb      (RegWrite_wb),
      .StallReq         (StallReq),
      .Count            (Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run one unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
      PipeRegWrite_wb  = we;
      PipeWriteAddr_wb = a;
      PipeWriteData_wb = d;
   endtask

   task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
      MduValid = v;
      MduAddr  = a;
      MduData  = d;
   endtask

   initial begin
      rst = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      mdu(1'b0, 5'd0, 32'h0);
      RsAddr_id = 5'd0;
      RtAddr_id = 5'd0;

      // reset then idle
      tick(); tick();
      settle();
      chk("rst_ready",  {31'd0, MduReady},    32'd0);
      chk("rst_count",  {29'd0, Count},       32'd0);
      chk("rst_we",     {31'd0, RegWrite_wb}, 32'd0);
      chk("rst_stall",  {31'd0, StallReq},    32'd0);
      rst = 1'b0;
      settle();
      chk("idle_ready", {31'd0, MduReady},    32'd1);

      // single push with idle pipe, no bypass
      tick();
      mdu(1'b1, 5'd5, 32'h1234_5678);
      RsAddr_id = 5'd5;
      settle();
      chk("nobypass_we",   {31'd0, RegWrite_wb}, 32'd0);
      chk("nobypass_pend", {31'd0, RsPend},      32'd0);
      tick();
      mdu(1'b0, 5'd0, 32'h0);
      settle();
      chk("q1_count", {29'd0, Count},        32'd1);
      chk("q1_we",    {31'd0, RegWrite_wb},  32'd1);
      chk("q1_addr",  {27'd0, RegWriteAddr_wb}, 32'd5);
      chk("q1_data",  RegWriteData_wb,       32'h1234_5678);
      chk("q1_rs",    {31'd0, RsPend},       32'd1);
      tick();
      settle();
      chk("q1_drained", {29'd0, Count},       32'd0);
      chk("q1_we_off",  {31'd0, RegWrite_wb}, 32'd0);
      chk("q1_rs_off",  {31'd0, RsPend},      32'd0);

      // fill behind a busy pipe, starve until StallReq
      pipe(1'b1, 5'd1, 32'hDEAD_0001);
      for (int i = 0; i < 4; i++) begin
         mdu(1'b1, 5'(10 + i), 32'h100 + i);
         tick();
      end
      mdu(1'b0, 5'd0, 32'h0);
      settle();
      chk("full_ready", {31'd0, MduReady},        32'd0);
      chk("full_count", {29'd0, Count},           32'd4);
      chk("full_paddr", {27'd0, RegWriteAddr_wb}, 32'd1);
      chk("full_pdata", RegWriteData_wb,          32'hDEAD_0001);
      // three blocked edges so far; four more keep StallReq low
      for (int i = 0; i < 4; i++) tick();
      settle();
      chk("starve7", {31'd0, StallReq}, 32'd0);
      tick();
      settle();
      chk("starve8", {31'd0, StallReq}, 32'd1);
      pipe(1'b0, 5'd0, 32'h0);
      settle();
      chk("bubble_addr", {27'd0, RegWriteAddr_wb}, 32'd10);
      chk("bubble_data", RegWriteData_wb,          32'h100);
      tick();
      settle();
      chk("bubble_count", {29'd0, Count},    32'd3);
      chk("stall_clear",  {31'd0, StallReq}, 32'd0);

      // full FIFO with a simultaneous pop: no ready credit, wrap order kept
      pipe(1'b1, 5'd1, 32'hDEAD_0001);
      mdu(1'b1, 5'd14, 32'h104);
      tick();
      pipe(1'b0, 5'd0, 32'h0);
      mdu(1'b1, 5'd15, 32'h105);
      settle();
      chk("popfull_ready", {31'd0, MduReady},        32'd0);
      chk("popfull_addr",  {27'd0, RegWriteAddr_wb}, 32'd11);
      tick();
      pipe(1'b1, 5'd1, 32'hDEAD_0001);
      settle();
      chk("popfull_count", {29'd0, Count},    32'd3);
      chk("retry_ready",   {31'd0, MduReady}, 32'd1);
      tick();
      mdu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      settle();
      chk("retry_count", {29'd0, Count}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("wrap_we",   {31'd0, RegWrite_wb},      32'd1);
         chk("wrap_addr", {27'd0, RegWriteAddr_wb},  32'(12 + i));
         chk("wrap_data", RegWriteData_wb,           32'h102 + i);
         tick();
      end
      settle();
      chk("wrap_empty", {29'd0, Count}, 32'd0);

      // WAW kill of a queued r7
      pipe(1'b1, 5'd1, 32'hDEAD_0001);
      mdu(1'b1, 5'd7, 32'h77);
      tick();
      mdu(1'b0, 5'd0, 32'h0);
      RtAddr_id = 5'd7;
      settle();
      chk("kill_pend_before", {31'd0, RtPend}, 32'd1);
      pipe(1'b1, 5'd7, 32'h0000_AAAA);
      settle();
      chk("kill_paddr", {27'd0, RegWriteAddr_wb}, 32'd7);
      chk("kill_pdata", RegWriteData_wb,          32'h0000_AAAA);
      tick();
      pipe(1'b0, 5'd0, 32'h0);
      settle();
      chk("kill_pend_after", {31'd0, RtPend},      32'd0);
      chk("kill_count",      {29'd0, Count},       32'd1);
      chk("kill_no_write",   {31'd0, RegWrite_wb}, 32'd0);
      tick();
      settle();
      chk("kill_drained", {29'd0, Count}, 32'd0);

      // same-cycle push to the register being written survives
      pipe(1'b1, 5'd8, 32'h0000_0088);
      mdu(1'b1, 5'd8, 32'h0000_8888);
      RtAddr_id = 5'd8;
      tick();
      mdu(1'b0, 5'd0, 32'h0);
      pipe(1'b0, 5'd0, 32'h0);
      settle();
      chk("newer_pend", {31'd0, RtPend},          32'd1);
      chk("newer_addr", {27'd0, RegWriteAddr_wb}, 32'd8);
      chk("newer_data", RegWriteData_wb,          32'h0000_8888);
      tick();

      // push to r0 is accepted and dropped
      mdu(1'b1, 5'd0, 32'hFFFF_FFFF);
      settle();
      chk("r0_ready", {31'd0, MduReady}, 32'd1);
      tick();
      mdu(1'b0, 5'd0, 32'h0);
      settle();
      chk("r0_count", {29'd0, Count},       32'd0);
      chk("r0_we",    {31'd0, RegWrite_wb}, 32'd0);

      // reset with three entries queued discards them
      pipe(1'b1, 5'd1, 32'hDEAD_0001);
      for (int i = 0; i < 3; i++) begin
         mdu(1'b1, 5'(20 + i), 32'h200 + i);
         tick();
      end
      mdu(1'b0, 5'd0, 32'h0);
      settle();
      chk("pre_rst_count", {29'd0, Count}, 32'd3);
      rst = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      RsAddr_id = 5'd20;
      settle();
      chk("midrst_we",    {31'd0, RegWrite_wb}, 32'd0);
      chk("midrst_ready", {31'd0, MduReady},    32'd0);
      tick();
      rst = 1'b0;
      settle();
      chk("postrst_count", {29'd0, Count},       32'd0);
      chk("postrst_we",    {31'd0, RegWrite_wb}, 32'd0);
      chk("postrst_pend",  {31'd0, RsPend},      32'd0);
      tick();
      settle();
      chk("postrst_idle", {31'd0, RegWrite_wb}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/wb_write_merger.md
Name: wb_write_merger

Overview:
- Write-side front end of the register file.
- Merges two producers onto the single register write port: the in-order WB stage and the long-latency multiply/divide unit (MDU).
- MDU results are held in a small FIFO and drained into WB slots that the pipeline leaves idle.
- Exports pending-write hits for the ID-stage source addresses so hazard logic can stall until queued results land.

Parameters:
DEPTH, 4, MDU result FIFO entries; power of two, minimum 2
STARVE_LIMIT, 8, consecutive blocked cycles before a bubble is requested; minimum 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
PipeWriteData_wb  input  32  WB-stage write data
PipeWriteAddr_wb  input  5  WB-stage destination register
PipeRegWrite_wb  input  1  WB-stage write enable
MduData  input  32  MDU result data
MduAddr  input  5  MDU destination register
MduValid  input  1  MDU result offered
MduReady  output  1  FIFO accepts the offered result
RsAddr_id  input  5  ID-stage rs address
RtAddr_id  input  5  ID-stage rt address
RsPend  output  1  rs has a queued live MDU write
RtPend  output  1  rt has a queued live MDU write
RegWriteData_wb  output  32  merged write data to register file
RegWriteAddr_wb  output  5  merged write address
RegWrite_wb  output  1  merged write enable
StallReq  output  1  request one pipeline bubble for draining
Count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- State: circular FIFO of {live, addr, data} entries; rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH; occupancy count runs 0..DEPTH; starvation counter; StallReq flop.
- Reset (rst=1 at an edge):
  - clears pointers, count, all live bits, starvation counter and StallReq.
  - MduReady is forced 0 while rst=1.
  - Write-port outputs still follow the pipeline inputs combinationally.
- Pipe slot busy = PipeRegWrite_wb && PipeWriteAddr_wb!=0.
- Write port (combinational):
  - If pipe slot busy: drive pipeline data, address and enable.
  - Else if the head entry is live: drive the head entry with RegWrite_wb=1.
  - Else: pass the pipeline inputs through. Enable is 0 when PipeWriteAddr_wb=0.
  - The pipeline always has priority and is never delayed.
- Push:
  - MduReady = !rst && count<DEPTH. Readiness does not credit a same-cycle pop.
  - On MduValid && MduReady with MduAddr!=0: write {1, MduAddr, MduData} at wr_ptr and advance wr_ptr.
  - MduAddr=0: accepted and discarded; no push.
- Pop:
  - A live head pops when it is driven onto the port (pipe slot not busy).
  - A dead head pops unconditionally in any cycle and produces no write.
  - At most one pop per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty FIFO: no bypass. A result pushed at edge N can write no earlier than cycle N+1, so minimum latency is 1 cycle.
- WAW kill:
  - When the pipe slot is busy with address A, every live entry with addr==A is cleared to dead at that edge. The pipeline write is program-order younger.
  - An entry being pushed the same cycle with addr A is stored live; the MDU result is the newer one.
- Pending outputs:
  - RsPend = RsAddr_id!=0 && any live entry has addr==RsAddr_id. RtPend is identical for RtAddr_id.
  - Both are combinational over registered FIFO state and do not include the same-cycle MDU input.
- Starvation:
  - The counter increments each cycle the head is live and not popped, and clears on any live pop or when the FIFO is empty.
  - StallReq is set at the edge where the counter reaches STARVE_LIMIT.
  - StallReq clears at the edge after a live pop.
  - The pipeline responds with a bubble (PipeRegWrite_wb=0).
- Reset mid-operation: all queued entries are discarded with no write issued; the MDU must reissue.

Test Plan:
- Reset then idle → MduReady=0 during rst, then 1; Count=0; RegWrite_wb=0 with pipe idle; StallReq=0.
- Pipe idle; push {r5, 0x1234_5678} → next cycle RegWrite_wb=1, addr 5, data 0x12345678; Count goes 1→0; RsPend=1 for RsAddr_id=5 only during the queued cycle.
- Pipe writes every cycle; push DEPTH=4 entries → MduReady=0 after 4th; Count=4; StallReq=1 at STARVE_LIMIT=8 blocked cycles; one bubble drains the head; StallReq then clears.
- Queue r7 behind busy pipe; pipe writes r7=0xAAAA → entry killed, RtPend(7)=0; later idle slot issues no write to r7; Count drops without RegWrite_wb.
- Full FIFO with simultaneous pop: MduValid held → MduReady=0 that cycle (no pop credit), accepted next cycle; pointers wrap 3→0 with order preserved.
- MduAddr=0 push → accepted, Count unchanged, no write; rst asserted with Count=3 → Count=0 next edge and no drain writes.
